// File: rtl/exc_requester_if.sv
// Bundles the CP0-facing signals of exc_requester: event/mask/handshake
// inputs and the request/status outputs.
interface exc_requester_if;
   logic [2:0] irq_in;
   logic [2:0] blockMask;
   logic       ExpBlock;
   logic       HasExp;
   logic       IsEret;
   logic       expSrc0;
   logic       expSrc1;
   logic       expSrc2;
   logic [2:0] pending;
   logic [1:0] inService;
   logic       busy;

   modport master (
      output irq_in, blockMask, ExpBlock, HasExp, IsEret,
      input  expSrc0, expSrc1, expSrc2, pending, inService, busy
   );

   modport slave (
      input  irq_in, blockMask, ExpBlock, HasExp, IsEret,
      output expSrc0, expSrc1, expSrc2, pending, inService, busy
   );
endinterface

// File: rtl/exc_requester.sv
// Three-source exception requester: latches irq edges, issues one request to
// CP0 at a time and tracks the serviced source. Optional timer: EXC_TIMER_EN.
module exc_requester #(
   parameter int ACK_TIMEOUT  = 16,
   parameter int TIMER_PERIOD = 1000
) (
   input  logic            clk,
   input  logic            rst,
   exc_requester_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_e;

   state_e     state_q, state_d;
   logic [2:0] irq_prev_q, irq_prev_d;
   logic [2:0] irq_arm_q, irq_arm_d;
   logic [2:0] pending_q, pending_d;
   logic [2:0] exp_q, exp_d;
   logic [1:0] src_q, src_d;
   logic [1:0] in_svc_q, in_svc_d;
   logic [7:0] cnt_q, cnt_d;

   logic [2:0] evt_irq, evt, eligible, grant_clr;
   logic [1:0] pick;
   logic       withdraw, timeout;

   // A source only arms once it has been seen low, so a level held high
   // across reset release does not count as an edge.
   assign evt_irq  = bus.irq_in & ~irq_prev_q & irq_arm_q;
   assign eligible = pending_q & ~bus.blockMask;
   assign pick     = eligible[2] ? 2'd2 : (eligible[1] ? 2'd1 : 2'd0);
   assign withdraw = bus.blockMask[src_q] | bus.ExpBlock;
   assign timeout  = (cnt_q == 8'(ACK_TIMEOUT - 1));

`ifdef EXC_TIMER_EN
   localparam int TW = $clog2(TIMER_PERIOD + 1);
   logic [TW-1:0] tmr_q, tmr_d;
   logic          tmr_evt;

   assign tmr_evt = (tmr_q == TW'(TIMER_PERIOD - 1));
   assign tmr_d   = tmr_evt ? '0 : tmr_q + 1'b1;
   assign evt     = evt_irq | {2'b00, tmr_evt};

   always_ff @(posedge clk) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`else
   logic unused_timer;
   assign unused_timer = ^32'(TIMER_PERIOD);
   assign evt          = evt_irq;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         irq_prev_q <= '0;
         irq_arm_q  <= '0;
         pending_q  <= '0;
         exp_q      <= '0;
         src_q      <= '0;
         in_svc_q   <= 2'd3;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         irq_prev_q <= irq_prev_d;
         irq_arm_q  <= irq_arm_d;
         pending_q  <= pending_d;
         exp_q      <= exp_d;
         src_q      <= src_d;
         in_svc_q   <= in_svc_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state logic; an ack takes precedence over withdraw and timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if ((|eligible) && !bus.ExpBlock) state_d = S_REQ;
         S_REQ:     if (bus.HasExp)                 state_d = S_SERVICE;
                    else if (withdraw || timeout)   state_d = S_IDLE;
         S_SERVICE: if (bus.IsEret)                 state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      irq_prev_d = bus.irq_in;
      irq_arm_d  = irq_arm_q | ~bus.irq_in;
      src_d      = src_q;
      in_svc_d   = in_svc_q;
      cnt_d      = '0;
      grant_clr  = '0;
      unique case (state_q)
         S_IDLE:    src_d = pick;
         S_REQ: begin
            if (state_d == S_REQ) cnt_d = cnt_q + 8'd1;
            if (bus.HasExp) begin
               grant_clr = 3'b001 << src_q;
               in_svc_d  = src_q;
            end
         end
         S_SERVICE: if (bus.IsEret) in_svc_d = 2'd3;
         default:   ;
      endcase
      // A new edge in the grant cycle survives the clear.
      pending_d = (pending_q & ~grant_clr) | evt;
      exp_d     = (state_d == S_REQ) ? (3'b001 << src_d) : 3'b000;
   end

   assign bus.expSrc0   = exp_q[0];
   assign bus.expSrc1   = exp_q[1];
   assign bus.expSrc2   = exp_q[2];
   assign bus.pending   = pending_q;
   assign bus.inService = in_svc_q;
   assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/exc_requester.md
EXC_REQUESTER -- requirements
Module: exc_requester

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, is the max cycles a request is held in REQ without acknowledge (range 2..255).
REQ-002 Parameter TIMER_PERIOD, default 1000, is the internal timer event period in clk cycles (used only with EXC_TIMER_EN).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 irq_in  input  3  peripheral event levels, already synchronous to clk; bit n feeds source n.
REQ-006 blockMask  input  3  per-source block bits from CP0 block register; 1 = source n masked.
REQ-007 ExpBlock  input  1  CP0 status[0]; 1 = no new request may be issued.
REQ-008 HasExp  input  1  CP0 exception-taken flag; level sampled at clk rising edge = acknowledge.
REQ-009 IsEret  input  1  ERET decoded in current instruction; level sampled at clk rising edge.
REQ-010 expSrc0/expSrc1/expSrc2  output  1 each  exception request lines to CP0, registered, at most one high.
REQ-011 pending  output  3  latched, not-yet-granted events per source.
REQ-012 inService  output  2  index of source being serviced (0..2); 3 = none.
REQ-013 busy  output  1  high in REQ or SERVICE state.

Function
REQ-014 Event: rising edge of irq_in[n] (registered previous value 0, current 1) sets pending[n]; levels held high produce one event.
REQ-015 FSM states IDLE, REQ, SERVICE; exactly one active.
REQ-016 IDLE: if (pending & ~blockMask) != 0 and ExpBlock = 0, pick highest index eligible (src2 > src1 > src0), go REQ next cycle, expSrcN high from that cycle.
REQ-017 REQ: expSrcN held high; on HasExp = 1, clear pending[N], inService = N, deassert expSrcN, go SERVICE (1-cycle latency).
REQ-018 REQ: if blockMask[N] or ExpBlock rises before ack, deassert expSrcN, go IDLE, pending[N] kept.
REQ-019 REQ: cycle counter starts at 0 on entry; at ACK_TIMEOUT cycles without ack, deassert, go IDLE, pending[N] kept; counter 8 bits, no wrap beyond timeout.
REQ-020 SERVICE: on IsEret = 1, inService = 3, go IDLE; new requests not issued before the IDLE cycle (no nesting).
REQ-021 IsEret in IDLE or REQ is ignored; HasExp in IDLE or SERVICE is ignored.
REQ-022 Same-cycle new event on source N and grant-clear of pending[N]: set wins, pending[N] stays 1.
REQ-023 Higher-priority event arriving during REQ does not preempt; it is latched and issued after return to IDLE.
REQ-024 Events during SERVICE latch into pending; none lost, duplicate events on same source merge into one.

Reset
REQ-025 rst = 1 at rising edge: state IDLE, pending = 0, edge registers = 0, counters = 0, expSrc0..2 = 0, inService = 3, busy = 0.
REQ-026 rst mid-REQ or mid-SERVICE aborts immediately; the high irq_in level present when rst releases is not an event until it falls and rises again.

Configuration
REQ-027 Macro EXC_TIMER_EN defined: internal counter 0..TIMER_PERIOD-1, wraps, emits one-cycle event at wrap, ORed with irq_in[0] edge event into pending[0]; counter reset to 0 by rst.
REQ-028 EXC_TIMER_EN undefined: no timer logic; pending[0] set only by irq_in[0] edges.

Verification
REQ-029 irq_in = 3'b010 edge, mask 0, ExpBlock 0 -> expSrc1 = 1 two cycles later; HasExp pulse -> expSrc1 = 0, pending = 0, inService = 1; IsEret -> inService = 3, busy = 0.
REQ-030 irq_in edges 3'b101 same cycle -> expSrc2 first; after ERET, expSrc0 issued; pending sequence 101 -> 001 -> 000.
REQ-031 Request on src0, no HasExp for 16 cycles -> expSrc0 drops at cycle 16, pending[0] = 1, re-request next IDLE cycle.
REQ-032 blockMask = 3'b100 with irq_in[2] edge -> no expSrc2; clear mask -> expSrc2 issued; ExpBlock = 1 during REQ -> withdrawn, pending kept.
REQ-033 rst asserted in SERVICE with pending = 3'b011 -> all outputs at reset values next cycle, pending = 0.
REQ-034 EXC_TIMER_EN, TIMER_PERIOD = 10 -> pending[0] set every 10 cycles; expSrc0 issued and acked each period.
